// File: rtl/gf22_sram_pkg.sv
// Shared constants and types for the GF22 8K x 64 single-port SRAM bank.
package gf22_sram_pkg;

  localparam int SRAM8K_DEPTH  = 8192;
  localparam int SRAM8K_WIDTH  = 64;
  localparam int SRAM8K_ADDR_W = 13;

  typedef logic [SRAM8K_WIDTH-1:0]  sram8k_word_t;
  typedef logic [SRAM8K_ADDR_W-1:0] sram8k_addr_t;

endpackage : gf22_sram_pkg

// File: rtl/gf22_sram_sp_8192x64.sv
// Single-port synchronous SRAM bank: 8192 x 64, per-bit write mask, registered read port.
module gf22_sram_sp_8192x64
  import gf22_sram_pkg::*;
#(
  parameter int DEPTH  = SRAM8K_DEPTH,
  parameter int WIDTH  = SRAM8K_WIDTH,
  parameter int ADDR_W = SRAM8K_ADDR_W
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [WIDTH-1:0]  D0,
  input  logic              WE0,
  input  logic [WIDTH-1:0]  WEM0,
  output logic [WIDTH-1:0]  Q0
);

  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
    $error("ADDR_W must equal log2(DEPTH)");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic wr_en;
  logic rd_en;

  assign wr_en = CE0 & WE0;
  assign rd_en = CE0 & ~WE0;

  // NOTE: the array has no reset branch so it maps onto a real macro; contents
  // survive reset, and the rst gate below only blocks writes while it is low.
  always_ff @(posedge CLK) begin
    if (rst && wr_en) begin
      mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
    end
  end

  // Q0 only moves on a read; writes and idle cycles leave the last read visible.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      Q0 <= '0;
    end else if (rd_en) begin
      Q0 <= mem[A0];
    end
  end

endmodule : gf22_sram_sp_8192x64

// File: tb/tb_gf22_sram_sp_8192x64.sv
// Scoreboard bench: reads push expected words, a negedge monitor pops and compares Q0.
module tb_gf22_sram_sp_8192x64;
  import gf22_sram_pkg::*;

  logic         CLK;
  logic         rst;
  logic         CE0;
  sram8k_addr_t A0;
  sram8k_word_t D0;
  logic         WE0;
  sram8k_word_t WEM0;
  sram8k_word_t Q0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    sram8k_addr_t addr;
    sram8k_word_t data;
  } exp_t;

  exp_t         exp_q[$];
  sram8k_word_t model [int];
  logic         rd_fire = 1'b0;

  gf22_sram_sp_8192x64 dut (
    .CLK  (CLK),
    .rst  (rst),
    .CE0  (CE0),
    .A0   (A0),
    .D0   (D0),
    .WE0  (WE0),
    .WEM0 (WEM0),
    .Q0   (Q0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input sram8k_word_t got, input sram8k_word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a read accepted at a rising edge must show on Q0 by the following falling edge.
  always @(posedge CLK) rd_fire <= (rst === 1'b1) && (CE0 === 1'b1) && (WE0 === 1'b0);

  always @(negedge CLK) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h expected nothing pending", Q0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("read_a%0h", e.addr), Q0, e.data);
      end
    end
  end

  // Reference model: a word is the old word with masked bits replaced by data bits.
  task automatic do_write(input sram8k_addr_t a, input sram8k_word_t d, input sram8k_word_t m);
    sram8k_word_t old;
    @(negedge CLK);
    CE0 = 1'b1; WE0 = 1'b1; A0 = a; D0 = d; WEM0 = m;
    old = model.exists(int'(a)) ? model[int'(a)] : '0;
    for (int i = 0; i < SRAM8K_WIDTH; i++) begin
      if (m[i]) old[i] = d[i];
    end
    if (rst) model[int'(a)] = old;
  endtask

  task automatic do_read(input sram8k_addr_t a);
    exp_t e;
    @(negedge CLK);
    CE0 = 1'b1; WE0 = 1'b0; A0 = a; D0 = '0; WEM0 = '0;
    e.addr = a;
    e.data = model[int'(a)];
    exp_q.push_back(e);
  endtask

  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      CE0 = 1'b0; WE0 = 1'b0; A0 = '0; D0 = '0; WEM0 = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    sram8k_addr_t pool [16];
    sram8k_word_t hold_v;

    rst = 1'b0; CE0 = 1'b0; WE0 = 1'b0; A0 = '0; D0 = '0; WEM0 = '0;
    repeat (3) @(negedge CLK);
    check("reset_q0", Q0, '0);
    rst = 1'b1;

    // Full write then read
    do_write(13'h0000, 64'h0123_4567_89AB_CDEF, '1);
    do_read(13'h0000);

    // Masked write clears only the middle 16 bits
    do_write(13'h1FFF, '1, '1);
    do_write(13'h1FFF, '0, 64'h0000_0000_FFFF_0000);
    do_read(13'h1FFF);
    check("mask_model", model[13'h1FFF], 64'hFFFF_FFFF_0000_FFFF);

    // Hold on idle and no write-through
    hold_v = 64'hAAAA_AAAA_AAAA_AAAA;
    do_write(13'd3, hold_v, '1);
    do_read(13'd3);
    do_idle(10);
    check("hold_idle", Q0, hold_v);
    do_write(13'd3, 64'h5555_5555_5555_5555, '1);
    @(negedge CLK);
    check("no_write_through", Q0, hold_v);
    do_read(13'd3);

    // Back-to-back reads
    for (int i = 0; i < 8; i++) do_write(sram8k_addr_t'(i), 64'(i) * 64'h1111, '1);
    for (int i = 0; i < 8; i++) do_read(sram8k_addr_t'(i));

    // Zero mask is a no-op write
    do_write(13'd7, 64'hFEED_FACE_CAFE_F00D, '0);
    do_read(13'd7);

    // Reset mid-simulation: Q0 clears asynchronously, contents survive, writes blocked
    do_write(13'd9, 64'h0BAD_0BAD_0BAD_0BAD, '1);
    do_write(13'd5, 64'hDEAD_BEEF_0000_0001, '1);
    do_read(13'd5);
    do_idle(1);
    #2;
    check("pre_reset_q0", Q0, 64'hDEAD_BEEF_0000_0001);
    rst = 1'b0;
    #1;
    check("async_reset_q0", Q0, '0);
    do_write(13'd9, 64'h0000_0000_0000_00FF, '1);
    do_read(13'd5);
    void'(exp_q.pop_back());
    @(negedge CLK);
    check("reset_hold_q0", Q0, '0);
    CE0 = 1'b0; WE0 = 1'b0;
    rst = 1'b1;
    do_read(13'd5);
    do_read(13'd9);
    check("reset_write_blocked", model[9], 64'h0BAD_0BAD_0BAD_0BAD);

    // Randomized mix of masked writes, reads and idles on a fully initialised pool
    for (int i = 0; i < 16; i++) begin
      pool[i] = sram8k_addr_t'($urandom_range(0, SRAM8K_DEPTH - 1));
      do_write(pool[i], {$urandom, $urandom}, '1);
    end
    for (int i = 0; i < 300; i++) begin
      sram8k_addr_t a;
      a = pool[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0:       do_write(a, {$urandom, $urandom}, {$urandom, $urandom});
        1:       do_write(a, {$urandom, $urandom}, '1);
        2:       do_read(a);
        default: begin
          do_read(a);
          do_idle($urandom_range(1, 3));
        end
      endcase
    end
    do_idle(1);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gf22_sram_sp_8192x64
